regfile_gen: RTL and testbench
==============================

# regfile_gen

Parametrised successor to the pipeline register file. It provides NRD registered read ports, one write port, a tapped observation register and a hardwired zero register. A hardware clear sequencer zeroes every register after reset, and `ready` tells the pipeline when the file is usable. The block sits in the decode stage: read data and captured read addresses register at the decode/execute boundary, and the write port is driven from writeback.

## Interface
Parameters:
- `XLEN`, 32, register width in bits
- `NREGS`, 32, number of registers; power of two, ≥ 4; AW = $clog2(NREGS)
- `NRD`, 2, number of read ports, 1..4
- `TAP_REG`, 1, index of the register mirrored on `tap`; 1..NREGS-1

Ports:
- `clk` in 1: single clock; all state updates on the rising edge
- `reset_n` in 1: reset, synchronous, active-low
- `stall` in 1: hold all registered outputs
- `we` in 1: write enable
- `wa` in AW: write address
- `wd` in XLEN: write data
- `ra` in NRD*AW: read addresses; port i at [i*AW +: AW]
- `rd` out NRD*XLEN: registered read data; port i at [i*XLEN +: XLEN]
- `ra_out` out NRD*AW: registered copy of `ra`
- `tap` out XLEN: registered value of register TAP_REG
- `ready` out 1: clear sequence done, file usable

## Operation
- State machine with two states:
  - CLEAR: entered on any edge with `reset_n`=0.
  - RUN: entered from CLEAR when the clear counter reaches NREGS-1.
- Reset edge (`reset_n`=0): state=CLEAR, clear counter=1. `rd`, `ra_out`, `tap` = 0; `ready`=0. Array contents are not touched by reset itself.
- CLEAR, each edge:
  - Writes 0 to register[counter], then increments the counter.
  - When the counter equals NREGS-1, that register is cleared, `ready`←1 and state←RUN.
  - `we` and `stall` are ignored; writes are dropped, not queued.
  - `rd`, `ra_out`, `tap` stay 0.
- RUN, write path: if `we`=1 and `wa`≠0, register[`wa`]←`wd`. The write happens regardless of `stall`.
- Register 0 always reads 0. A write to address 0 is discarded.
- RUN with `stall`=0, each edge, for each port i:
  - `ra_out`[i]←`ra`[i]
  - `rd`[i]←register[`ra`[i]], subject to the bypass rule under Configuration
  - `tap`←register[TAP_REG], with the same bypass rule applied
- RUN with `stall`=1: `rd`, `ra_out` and `tap` hold their values.
- Read ports are independent. Several ports may address the same register. Read address 0 always returns 0, even when `wa`=0 with `we`=1.

## Timing
- Read latency: 1 cycle. Address presented before edge N → data valid after edge N.
- Write visibility:
  - With bypass: a read in the same cycle as the write sees the new value.
  - Without bypass: the new value is visible from the next read cycle onward.
- Clear duration: `ready` rises on the (NREGS-1)th edge with `reset_n`=1, counting from the first such edge. For NREGS=32 this is the 31st edge.
- Reset asserted mid-CLEAR or mid-RUN: takes effect on that edge and restarts the clear sequence at counter=1. Stall and write inputs are irrelevant on that edge.
- `ready` is 0 from the first reset edge until clear completes, and stays 1 until the next reset edge.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - In RUN, when `we`=1, `wa`≠0 and `wa`==`ra`[i], `rd`[i] loads `wd` rather than the array value.
  - Likewise `tap` loads `wd` when `wa`==TAP_REG.
- `REGFILE_BYPASS_EN` undefined:
  - `rd` and `tap` always load the pre-write array value.
  - The pipeline resolves the one-cycle write-to-read hazard by stalling or forwarding upstream.

## Test plan
- Reset/clear, default parameters: hold `reset_n`=0 for 2 edges, then release; drive `we`=1, `wa`=5, `wd`=0xDEAD_BEEF throughout.
  - `ready`=0 for edges 1..30; `ready`=1 after edge 31.
  - Reading register 5 afterwards returns 0 (write dropped during CLEAR).
- Basic write/read:
  - Write 0x1234_5678 to register 7.
  - Next cycle set `ra`[0]=7, `ra`[1]=0 → after one edge `rd`[0]=0x1234_5678, `rd`[1]=0, `ra_out`={0,7}.
- Same-cycle hazard: `we`=1, `wa`=3, `wd`=0xA5A5_A5A5, `ra`[0]=3, register 3 previously 0x11.
  - Bypass build: `rd`[0]=0xA5A5_A5A5.
  - Non-bypass build: `rd`[0]=0x11, and 0xA5A5_A5A5 on the following read.
- x0 and tap:
  - Write 0xFFFF_FFFF to address 0, then read address 0 on both ports → 0.
  - Write 0x42 to register 1 → `tap`=0x42 after one edge (bypass build) or two edges (non-bypass build).
- Stall:
  - With `rd`[0]=0x10, assert `stall` for 3 edges while writing 0x20 to the read register and changing `ra`.
  - `rd`/`ra_out`/`tap` are unchanged during stall; the write lands, and the read after `stall` drops returns 0x20.
- Reset mid-RUN: populate registers 1..4, assert `reset_n`=0 for 1 edge.
  - `ready` drops immediately and outputs go to 0.
  - After the new clear completes, registers 1..4 read 0.

Source files
------------

// File: rtl/regfile_gen.sv
// Parametrised decode-stage register file: NRD registered read ports, one write port, tap and x0.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto rd/tap.
//
// state | meaning
// CLEAR | sequencer zeroing registers 1..NREGS-1, ports inert, ready=0
// RUN   | normal read/write operation, ready=1
module regfile_gen #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int NRD     = 2,
  parameter int TAP_REG = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          stall,
  input  logic                          we,
  input  logic [$clog2(NREGS)-1:0]      wa,
  input  logic [XLEN-1:0]               wd,
  input  logic [NRD*$clog2(NREGS)-1:0]  ra,
  output logic [NRD*XLEN-1:0]           rd,
  output logic [NRD*$clog2(NREGS)-1:0]  ra_out,
  output logic [XLEN-1:0]               tap,
  output logic                          ready
);
  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] LAST_A = AW'(NREGS - 1);
  localparam logic [AW-1:0] TAP_A  = AW'(TAP_REG);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state, state_next;
  logic [AW-1:0]   cnt;
  logic [XLEN-1:0] mem [NREGS];
  logic            clr_done, wr_run;
  logic            mem_we;
  logic [AW-1:0]   mem_wa;
  logic [XLEN-1:0] mem_wd;
  logic [XLEN-1:0] rd_next [NRD];
  logic [XLEN-1:0] tap_next;

  always_comb begin
    state_next = state;
    clr_done   = (state == CLEAR) && (cnt == LAST_A);
    if (clr_done) state_next = RUN;

    wr_run = (state == RUN) && we && (wa != '0);
    mem_we = (state == CLEAR) || wr_run;
    mem_wa = (state == CLEAR) ? cnt : wa;
    mem_wd = (state == CLEAR) ? '0 : wd;
  end

  // Register 0 is never written by the sequencer; address 0 is forced to zero on read instead.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd_next[i] = mem[ra[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      if (wr_run && (wa == ra[i*AW +: AW])) rd_next[i] = wd;
`endif
      if (ra[i*AW +: AW] == '0) rd_next[i] = '0;
    end
    tap_next = mem[TAP_A];
`ifdef REGFILE_BYPASS_EN
    if (wr_run && (wa == TAP_A)) tap_next = wd;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= CLEAR;
    else          state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt   <= AW'(1);
      ready <= 1'b0;
    end else if (state == CLEAR) begin
      cnt <= cnt + AW'(1);
      if (clr_done) ready <= 1'b1;
    end
  end

  // Array has no reset; the clear sequencer owns initialisation.
  always_ff @(posedge clk) begin
    if (reset_n && mem_we) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk) begin
    if (!reset_n || (state == CLEAR)) begin
      rd     <= '0;
      ra_out <= '0;
      tap    <= '0;
    end else if (!stall) begin
      for (int i = 0; i < NRD; i++) rd[i*XLEN +: XLEN] <= rd_next[i];
      ra_out <= ra;
      tap    <= tap_next;
    end
  end

endmodule

// File: tb/tb_regfile_gen.sv
// Scoreboard bench for regfile_gen with default parameters; expectations follow REGFILE_BYPASS_EN.
module tb_regfile_gen;
  localparam int XLEN = 32, NREGS = 32, NRD = 2, AW = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset_n, stall, we;
  logic [AW-1:0]       wa;
  logic [XLEN-1:0]     wd;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD*AW-1:0]   ra_out;
  logic [XLEN-1:0]     tap;
  logic                ready;

  regfile_gen #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .TAP_REG(1)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .we(we), .wa(wa), .wd(wd),
    .ra(ra), .rd(rd), .ra_out(ra_out), .tap(tap), .ready(ready)
  );

  always #5 clk = ~clk;

  // sel: 0=rd[0] 1=rd[1] 2=ra_out 3=tap 4=ready
  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void push(string name, int sel, logic [31:0] val);
    exp_t e;
    e.name = name; e.sel = sel; e.val = val;
    q.push_back(e);
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.sel)
        0:       act = rd[0*XLEN +: XLEN];
        1:       act = rd[1*XLEN +: XLEN];
        2:       act = 32'(ra_out);
        3:       act = tap;
        default: act = 32'(ready);
      endcase
      n_tests++;
      if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    we = 1'b1; wa = a; wd = d;
    tick();
    we = 1'b0;
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    ra = {a1, a0};
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF; ra = '0;
    tick(); tick();
    push("reset_ready", 4, 0);
    push("reset_rd0", 0, 0);
    push("reset_tap", 3, 0);
    reset_n = 1'b1;
    for (int e = 1; e <= 31; e++) begin
      tick();
      push($sformatf("clear_ready_e%0d", e), 4, (e >= 31) ? 32'd1 : 32'd0);
      if (e == 10) push("clear_rd0_zero", 0, 0);
    end
    we = 1'b0;

    set_ra(5'd5, 5'd0);
    tick();
    push("dropped_write_r5", 0, 0);

    wr(5'd7, 32'h1234_5678);
    set_ra(5'd7, 5'd0);
    tick();
    push("basic_rd0", 0, 32'h1234_5678);
    push("basic_rd1", 1, 0);
    push("basic_ra_out", 2, 32'd7);

    wr(5'd3, 32'h11);
    set_ra(5'd3, 5'd0);
    we = 1'b1; wa = 5'd3; wd = 32'hA5A5_A5A5;
    tick();
    we = 1'b0;
    push("hazard_same_cycle", 0, BYP ? 32'hA5A5_A5A5 : 32'h11);
    tick();
    push("hazard_next", 0, 32'hA5A5_A5A5);

    set_ra(5'd0, 5'd0);
    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF;
    tick();
    we = 1'b0;
    push("x0_same_rd0", 0, 0);
    push("x0_same_rd1", 1, 0);
    tick();
    push("x0_after_rd0", 0, 0);
    push("x0_after_rd1", 1, 0);

    wr(5'd1, 32'h42);
    push("tap_first", 3, BYP ? 32'h42 : 32'h0);
    tick();
    push("tap_second", 3, 32'h42);

    wr(5'd9, 32'h10);
    set_ra(5'd9, 5'd0);
    tick();
    push("stall_pre_rd0", 0, 32'h10);
    stall = 1'b1; we = 1'b1; wa = 5'd9; wd = 32'h20; set_ra(5'd7, 5'd3);
    for (int s = 0; s < 3; s++) begin
      tick();
      push($sformatf("stall_rd0_%0d", s), 0, 32'h10);
      push($sformatf("stall_ra_out_%0d", s), 2, 32'd9);
      push($sformatf("stall_tap_%0d", s), 3, 32'h42);
    end
    stall = 1'b0; we = 1'b0; set_ra(5'd9, 5'd0);
    tick();
    push("stall_post_rd0", 0, 32'h20);
    push("stall_post_ra_out", 2, 32'd9);

    wr(5'd1, 32'hA1); wr(5'd2, 32'hA2); wr(5'd3, 32'hA3); wr(5'd4, 32'hA4);
    set_ra(5'd1, 5'd2);
    tick();
    push("pre_rst_rd0", 0, 32'hA1);
    push("pre_rst_rd1", 1, 32'hA2);
    push("pre_rst_tap", 3, 32'hA1);
    reset_n = 1'b0; stall = 1'b1; we = 1'b1; wa = 5'd2; wd = 32'h55;
    tick();
    push("midrst_ready", 4, 0);
    push("midrst_rd0", 0, 0);
    push("midrst_rd1", 1, 0);
    push("midrst_ra_out", 2, 0);
    push("midrst_tap", 3, 0);
    reset_n = 1'b1; stall = 1'b0; we = 1'b0; set_ra(5'd3, 5'd4);
    for (int e = 1; e <= 31; e++) begin
      tick();
      if (e == 30) push("reclear_ready_e30", 4, 0);
    end
    push("reclear_ready_e31", 4, 1);
    tick();
    push("cleared_r3", 0, 0);
    push("cleared_r4", 1, 0);
    set_ra(5'd1, 5'd2);
    tick();
    push("cleared_r1", 0, 0);
    push("cleared_r2", 1, 0);
    push("cleared_tap", 3, 0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
